// File: rtl/bit_packer_acc.sv
// bit_packer_acc
//   Back end of the compressor's right-shift aligner. Each accepted code has
//   already been shifted right by the current fill level. It is masked to its
//   legal length and ORed into a WIDTH-bit accumulator. Whenever at least
//   O_WIDTH bits are held, the top O_WIDTH bits leave as one packed word,
//   MSB first, on a valid/ready stream. A flush pads the partial word with
//   zero LSBs and emits it.
//
// Ports
//   i_clk, i_rst_n   clock (rising edge), async active-low reset
//   i_valid/i_ready  code handshake; i_shifted = aligned code, i_len = length
//   i_flush          request a pad-and-emit, sampled together with i_ready
//   o_amt            current fill level, returned to the aligner as its shift
//   o_valid/o_ready  packed-word handshake; o_word = packed word
//   o_flush_done     one-cycle pulse at the end of a flush
//   o_word_cnt       words emitted since reset, wraps
//   o_err            sticky flag, an over-length code was seen
module bit_packer_acc #(
    parameter int WIDTH     = 196,
    parameter int O_WIDTH   = 128,
    parameter int MAX_LEN   = WIDTH - O_WIDTH,
    parameter int SHIFT_BIT = $clog2(WIDTH),
    parameter int CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [WIDTH-1:0]     i_shifted,
    input  logic [7:0]           i_len,
    input  logic                 i_flush,
    output logic [SHIFT_BIT-1:0] o_amt,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [O_WIDTH-1:0]   o_word,
    output logic                 o_flush_done,
    output logic [CNT_W-1:0]     o_word_cnt,
    output logic                 o_err
);

    // One extra bit so that fill + len never wraps, whatever the parameters.
    localparam int FW = SHIFT_BIT + 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     acc;
    logic [SHIFT_BIT-1:0] fill;

    logic                 out_free;
    logic                 accept;
    logic                 len_ovf;
    logic [7:0]           len_c;
    logic [WIDTH-1:0]     len_mask;
    logic [WIDTH-1:0]     code_mask;
    logic [WIDTH-1:0]     nacc;
    logic [FW-1:0]        nfill;
    logic                 emit;

    // The output register can take a new word if it is empty, or if it is
    // being drained in this same cycle.
    assign out_free = !o_valid || o_ready;
    assign i_ready  = out_free && (state == S_RUN);
    assign accept   = i_valid && i_ready;
    assign o_amt    = fill;

    // Clamp the length. The mask keeps only the len_c bits that start at
    // the current fill position. Anything the aligner placed outside that
    // window is dropped. A length of 0 gives an all-zero mask, so the
    // accumulator is unchanged.
    assign len_ovf   = i_len > 8'(MAX_LEN);
    assign len_c     = len_ovf ? 8'(MAX_LEN) : i_len;
    assign len_mask  = ~({WIDTH{1'b1}} >> len_c);
    assign code_mask = len_mask >> fill;
    assign nacc      = acc | (i_shifted & code_mask);
    assign nfill     = FW'(fill) + FW'(len_c);
    assign emit      = nfill >= FW'(O_WIDTH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_RUN;
            acc          <= '0;
            fill         <= '0;
            o_valid      <= 1'b0;
            o_word       <= '0;
            o_flush_done <= 1'b0;
            o_word_cnt   <= '0;
            o_err        <= 1'b0;
        end else begin
            o_flush_done <= 1'b0;
            // Drain on handshake. A load later in this block takes priority.
            if (o_valid && o_ready)
                o_valid <= 1'b0;

            case (state)
                S_RUN: begin
                    if (accept) begin
                        if (len_ovf)
                            o_err <= 1'b1;
                        if (emit) begin
                            o_word     <= nacc[WIDTH-1 -: O_WIDTH];
                            o_valid    <= 1'b1;
                            o_word_cnt <= o_word_cnt + 1'b1;
                            acc        <= nacc << O_WIDTH;
                            fill       <= SHIFT_BIT'(nfill - FW'(O_WIDTH));
                        end else begin
                            acc  <= nacc;
                            fill <= SHIFT_BIT'(nfill);
                        end
                    end
                    // Any code arriving in the same cycle is merged first.
                    // The flush then applies to the merged state.
                    if (i_flush && i_ready)
                        state <= S_FLUSH;
                end

                S_FLUSH: begin
                    if (out_free) begin
                        if (fill != '0) begin
                            o_word     <= acc[WIDTH-1 -: O_WIDTH];
                            o_valid    <= 1'b1;
                            o_word_cnt <= o_word_cnt + 1'b1;
                        end
                        acc          <= '0;
                        fill         <= '0;
                        o_flush_done <= 1'b1;
                        state        <= S_DONE;
                    end
                end

                S_DONE: begin
                    state <= S_RUN;
                end

                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule
